// File: rtl/perf_counter_bank.sv
// perf_counter_bank: per-channel event counters plus a free-running cycle
// counter, with a RUN/FROZEN gate driven by halt/clear, sticky overflow
// flags, a snapshot shadow bank and a one-cycle-latency read port that
// reads from the shadows.
module perf_counter_bank #(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 32,
  parameter int SAT    = 0,
  localparam int AW    = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              enable_i,
  input  logic              halt_i,
  input  logic              clear_i,
  input  logic              snap_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic              halted_o,
  output logic [NUM_CH-1:0] overflow_o
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FROZEN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [AW-1:0]    ADDR_CYC = AW'(NUM_CH);

  // Increment with the configured overflow policy.
  // Result bit CNT_W flags an attempted increment past the maximum value.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] r;
    if (v == CNT_MAX) begin
      r = {1'b1, ((SAT != 0) ? CNT_MAX : {CNT_W{1'b0}})};
    end else begin
      r = {1'b0, v + {{(CNT_W-1){1'b0}}, 1'b1}};
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W:0]    bump_s [NUM_CH];
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W:0]    cyc_bump_s;
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CNT_W-1:0]  shadow_q [NUM_CH+1];
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              count_en_s;

  // Counting happens only while running and enabled; a halt in the same
  // cycle still lets that cycle's events and tick through.
  always_comb begin
    count_en_s = (state_q == ST_RUN) && enable_i;
  end

  // Candidate incremented values for every live counter.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      bump_s[i] = bump(cnt_q[i]);
    end
    cyc_bump_s = bump(cyc_q);
  end

  // Next value of channel counters and overflow flags; clear wins.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_i) begin
        cnt_d[i] = {CNT_W{1'b0}};
        ovf_d[i] = 1'b0;
      end else if (count_en_s && event_i[i]) begin
        cnt_d[i] = bump_s[i][CNT_W-1:0];
        ovf_d[i] = ovf_q[i] | bump_s[i][CNT_W];
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Next value of the cycle counter (same overflow policy, no flag).
  always_comb begin
    cyc_d = cyc_q;
    if (clear_i) begin
      cyc_d = {CNT_W{1'b0}};
    end else if (count_en_s) begin
      cyc_d = cyc_bump_s[CNT_W-1:0];
    end else begin
      cyc_d = cyc_q;
    end
  end

  // RUN/FROZEN transitions: clear always returns to RUN, halt freezes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (clear_i) begin
          state_d = ST_RUN;
        end else if (halt_i) begin
          state_d = ST_FROZEN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FROZEN: begin
        if (clear_i) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FROZEN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Read mux over the shadow bank; addresses past the cycle slot read zero.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      if (rd_addr_i <= ADDR_CYC) begin
        rd_data_d = shadow_q[rd_addr_i];
      end else begin
        rd_data_d = {CNT_W{1'b0}};
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Live counters, flags and FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cyc_q   <= {CNT_W{1'b0}};
      ovf_q   <= {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Shadow bank captures pre-update live values on snap; clear leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= NUM_CH; i++) begin
        shadow_q[i] <= {CNT_W{1'b0}};
      end
    end else if (snap_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_q[i] <= cnt_q[i];
      end
      shadow_q[NUM_CH] <= cyc_q;
    end else begin
      for (int i = 0; i <= NUM_CH; i++) begin
        shadow_q[i] <= shadow_q[i];
      end
    end
  end

  // Registered read port; data holds between reads, valid pulses per read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= {CNT_W{1'b0}};
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign cycle_count_o = cyc_q;
  assign halted_o      = (state_q == ST_FROZEN);
  assign overflow_o    = ovf_q;

endmodule
